reg_cmd_ctrl: RTL and testbench

//  Command-side master for the 16x8 register file. Decodes byte frames from the serial RX path and

---
 rtl/reg_cmd_pkg.sv | 32 +++
 rtl/cmd_timeout_cnt.sv | 33 +++
 rtl/reg_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_pkg.sv
`default_nettype none
// ============================================================================
// reg_cmd_pkg : opcodes and FSM encoding shared by the register command master
// Revision    : 1.0
// ============================================================================
package reg_cmd_pkg;

   localparam logic [7:0] OP_WR = 8'hAA;
   localparam logic [7:0] OP_RD = 8'hBB;

   localparam int TO_CNT_W = 8;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR_ADDR  = 3'd1;
   localparam logic [2:0] ST_WR_DATA  = 3'd2;
   localparam logic [2:0] ST_RD_ADDR  = 3'd3;
   localparam logic [2:0] ST_RD_ISSUE = 3'd4;
   localparam logic [2:0] ST_RD_WAIT  = 3'd5;
   localparam logic [2:0] ST_TX_SEND  = 3'd6;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      WR_ADDR  = ST_WR_ADDR,
      WR_DATA  = ST_WR_DATA,
      RD_ADDR  = ST_RD_ADDR,
      RD_ISSUE = ST_RD_ISSUE,
      RD_WAIT  = ST_RD_WAIT,
      TX_SEND  = ST_TX_SEND
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_cnt.sv
`default_nettype none
// ============================================================================
// cmd_timeout_cnt : saturating idle counter with terminal-count flag
// Revision        : 1.0
// ============================================================================
module cmd_timeout_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Flags during the limit-th counted cycle so the registered error lands right after it
   assign o_tc = i_en && !i_clr && (r_cnt >= (i_limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/reg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// reg_cmd_ctrl : decodes RX byte frames into register-file write/read
//                transactions and returns read data to the TX path
// Revision     : 1.0
// ============================================================================
module reg_cmd_ctrl
   import reg_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FRAME_TO   = 255,
   parameter int RD_TO      = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_VLD,
   input  logic                  TX_Busy,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  cmd_err
);

   localparam logic [TO_CNT_W-1:0] c_frame_to = TO_CNT_W'(FRAME_TO);
   localparam logic [TO_CNT_W-1:0] c_rd_to    = TO_CNT_W'(RD_TO);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_wren_nxt;
   logic                  w_rden_nxt;
   logic                  w_txvld_nxt;
   logic                  w_err_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DATA_WIDTH-1:0] w_wdata_nxt;
   logic [DATA_WIDTH-1:0] w_txdata_nxt;

   logic                  w_frame_st;
   logic                  w_cnt_en;
   logic                  w_cnt_clr;
   logic [TO_CNT_W-1:0]   w_limit;
   logic                  w_tc;
   logic                  w_addr_bad;

   assign w_frame_st = (r_state == WR_ADDR) || (r_state == WR_DATA) || (r_state == RD_ADDR);
   assign w_cnt_en   = w_frame_st || (r_state == RD_WAIT);
   // Clearing depends only on state and inputs, keeping tc free of a loop through next-state
   assign w_cnt_clr  = !w_cnt_en || (w_frame_st && RX_D_VLD);
   assign w_limit    = (r_state == RD_WAIT) ? c_rd_to : c_frame_to;
   assign w_addr_bad = (RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] != '0);

   cmd_timeout_cnt #(
      .CNT_W   (TO_CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .i_limit (w_limit),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         TX_D_VLD  <= 1'b0;
         cmd_err   <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         TX_P_DATA <= '0;
      end else begin
         r_state   <= w_state_nxt;
         WrEn      <= w_wren_nxt;
         RdEn      <= w_rden_nxt;
         TX_D_VLD  <= w_txvld_nxt;
         cmd_err   <= w_err_nxt;
         Address   <= w_addr_nxt;
         WrData    <= w_wdata_nxt;
         TX_P_DATA <= w_txdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_wren_nxt   = 1'b0;
      w_rden_nxt   = 1'b0;
      w_txvld_nxt  = 1'b0;
      w_err_nxt    = 1'b0;
      w_addr_nxt   = Address;
      w_wdata_nxt  = WrData;
      w_txdata_nxt = TX_P_DATA;
      case (r_state)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == OP_WR)      w_state_nxt = WR_ADDR;
               else if (RX_P_DATA == OP_RD) w_state_nxt = RD_ADDR;
               else                         w_err_nxt   = 1'b1;
            end
         end
         WR_ADDR, RD_ADDR: begin
            if (RX_D_VLD) begin
               if (w_addr_bad) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                  w_state_nxt = (r_state == WR_ADDR) ? WR_DATA : RD_ISSUE;
               end
            end else if (w_tc) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               w_wdata_nxt = RX_P_DATA;
               w_wren_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_tc) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         RD_ISSUE: begin
            w_err_nxt   = RX_D_VLD;
            w_rden_nxt  = 1'b1;
            w_state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            w_err_nxt = RX_D_VLD;
            if (RdData_VLD) begin
               w_txdata_nxt = RdData;
               // An idle serializer takes the byte straight away to meet the one-cycle latency
               if (!TX_Busy) begin
                  w_txvld_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = TX_SEND;
               end
            end else if (w_tc) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         TX_SEND: begin
            w_err_nxt = RX_D_VLD;
            if (!TX_Busy) begin
               w_txvld_nxt = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_reg_cmd_ctrl : scoreboard bench with a behavioural 16x8 register file
// Revision        : 1.0
// ============================================================================
module tb_reg_cmd_ctrl;

   localparam int FRAME_TO = 255;
   localparam int RD_TO    = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] RX_P_DATA = 8'h00;
   logic       RX_D_VLD = 1'b0;
   logic [7:0] RdData;
   logic       RdData_VLD;
   logic       TX_Busy = 1'b0;
   logic       WrEn, RdEn, TX_D_VLD, cmd_err;
   logic [3:0] Address;
   logic [7:0] WrData, TX_P_DATA;

   reg_cmd_ctrl #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4),
      .FRAME_TO   (FRAME_TO),
      .RD_TO      (RD_TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .RX_P_DATA  (RX_P_DATA),
      .RX_D_VLD   (RX_D_VLD),
      .RdData     (RdData),
      .RdData_VLD (RdData_VLD),
      .TX_Busy    (TX_Busy),
      .WrEn       (WrEn),
      .RdEn       (RdEn),
      .Address    (Address),
      .WrData     (WrData),
      .TX_P_DATA  (TX_P_DATA),
      .TX_D_VLD   (TX_D_VLD),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // register file: REG2 resets to 0x81, everything else to 0; reads answer one cycle after RdEn
   logic [7:0] rf_mem [16];
   logic       rf_mute = 1'b0;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) rf_mem[i] <= (i == 2) ? 8'h81 : 8'h00;
         RdData_VLD <= 1'b0;
         RdData     <= 8'h00;
      end else begin
         RdData_VLD <= RdEn && !rf_mute;
         if (RdEn) RdData <= rf_mem[Address];
         if (WrEn) rf_mem[Address] <= WrData;
      end
   end

   logic [7:0] shadow [16];
   task automatic shadow_reset();
      for (int i = 0; i < 16; i++) shadow[i] = (i == 2) ? 8'h81 : 8'h00;
   endtask

   typedef struct {
      int         cyc;
      logic [7:0] a;
      logic [7:0] d;
   } ev_t;

   ev_t q_wr[$];
   ev_t q_rd[$];
   ev_t q_tx[$];
   ev_t q_err[$];

   // monitor: every DUT event must match the head of its queue in cycle and payload
   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         chk("wr_rd_exclusive", {31'd0, WrEn & RdEn}, 32'd0);
         if (WrEn) begin
            if (q_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
               e = q_wr.pop_front();
               chk("wr_cycle", cyc, e.cyc);
               chk("wr_addr", {28'd0, Address}, {24'd0, e.a});
               chk("wr_data", {24'd0, WrData}, {24'd0, e.d});
            end
         end
         if (RdEn) begin
            if (q_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
               e = q_rd.pop_front();
               chk("rd_cycle", cyc, e.cyc);
               chk("rd_addr", {28'd0, Address}, {24'd0, e.a});
            end
         end
         if (TX_D_VLD) begin
            if (q_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
            else begin
               e = q_tx.pop_front();
               chk("tx_cycle", cyc, e.cyc);
               chk("tx_data", {24'd0, TX_P_DATA}, {24'd0, e.d});
            end
         end
         if (cmd_err) begin
            if (q_err.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
            else begin
               e = q_err.pop_front();
               chk("err_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, output int c);
      @(posedge clk); #1;
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      c = cyc;
   endtask

   task automatic release_rx();
      @(posedge clk); #1;
      RX_D_VLD = 1'b0;
   endtask

   task automatic goto_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk); #1;
      end
   endtask

   // leaves RX_D_VLD high so frames can follow back-to-back
   task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
      int c;
      send(8'hAA, c);
      send({4'h0, addr}, c);
      send(data, c);
      q_wr.push_back('{cyc: c + 1, a: {4'h0, addr}, d: data});
      shadow[addr] = data;
   endtask

   task automatic do_read(input logic [3:0] addr);
      int c;
      send(8'hBB, c);
      send({4'h0, addr}, c);
      q_rd.push_back('{cyc: c + 2, a: {4'h0, addr}, d: 8'h00});
      q_tx.push_back('{cyc: c + 4, a: {4'h0, addr}, d: shadow[addr]});
      release_rx();
      goto_cyc(c + 6);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_wren"},  {31'd0, WrEn},      32'd0);
      chk({tag, "_rden"},  {31'd0, RdEn},      32'd0);
      chk({tag, "_txvld"}, {31'd0, TX_D_VLD},  32'd0);
      chk({tag, "_err"},   {31'd0, cmd_err},   32'd0);
      chk({tag, "_addr"},  {28'd0, Address},   32'd0);
      chk({tag, "_wdata"}, {24'd0, WrData},    32'd0);
      chk({tag, "_txdata"},{24'd0, TX_P_DATA}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, b;
      logic [3:0] ra [6];
      shadow_reset();

      #2 rst = 1'b0;
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // write then reads, including a held-value check
      do_write(4'h3, 8'h5C);
      release_rx();
      do_read(4'h2);
      chk("hold_addr", {28'd0, Address}, 32'd2);
      chk("hold_wdata", {24'd0, WrData}, 32'h5C);
      do_read(4'h3);

      // bad opcode
      send(8'h7E, c);
      q_err.push_back('{cyc: c + 1, a: 8'h00, d: 8'h00});
      release_rx();
      goto_cyc(c + 4);

      // non-zero high nibble in the address byte
      send(8'hAA, c);
      send(8'h13, c);
      q_err.push_back('{cyc: c + 1, a: 8'h00, d: 8'h00});
      release_rx();
      goto_cyc(c + 4);

      // frame timeout after a lone opcode
      send(8'hAA, c);
      q_err.push_back('{cyc: c + FRAME_TO + 1, a: 8'h00, d: 8'h00});
      release_rx();
      goto_cyc(c + FRAME_TO + 5);

      // read timeout: register file never answers
      rf_mute = 1'b1;
      send(8'hBB, c);
      send(8'h07, c);
      q_rd.push_back('{cyc: c + 2, a: 8'h07, d: 8'h00});
      q_err.push_back('{cyc: c + 2 + RD_TO, a: 8'h00, d: 8'h00});
      release_rx();
      goto_cyc(c + RD_TO + 8);
      rf_mute = 1'b0;

      // TX backpressure with a stray byte dropped while waiting
      TX_Busy = 1'b1;
      send(8'hBB, c);
      send(8'h03, c);
      q_rd.push_back('{cyc: c + 2, a: 8'h03, d: 8'h00});
      release_rx();
      goto_cyc(c + 8);
      send(8'h11, c2);
      q_err.push_back('{cyc: c2 + 1, a: 8'h00, d: 8'h00});
      release_rx();
      b = c + 22;
      goto_cyc(b);
      TX_Busy = 1'b0;
      q_tx.push_back('{cyc: b + 1, a: 8'h03, d: 8'h5C});
      goto_cyc(b + 4);

      // back-to-back random writes, then read each back
      for (int i = 0; i < 6; i++) begin
         ra[i] = 4'($urandom_range(0, 15));
         do_write(ra[i], 8'($urandom));
      end
      release_rx();
      for (int i = 0; i < 6; i++) do_read(ra[i]);

      // reset in the middle of a write frame
      send(8'hAA, c);
      send(8'h05, c);
      release_rx();
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      @(posedge clk); #1;
      rst = 1'b1;
      shadow_reset();
      do_read(4'h5);
      do_read(4'h2);

      repeat (5) @(posedge clk);
      #1;
      chk("q_wr_empty",  q_wr.size(),  32'd0);
      chk("q_rd_empty",  q_rd.size(),  32'd0);
      chk("q_tx_empty",  q_tx.size(),  32'd0);
      chk("q_err_empty", q_err.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
